// File: rtl/seq_alu_core_if.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_core_if
//  Purpose  : Operation/result handshake bundle for seq_alu_core.
//  Ports    : master -> drives in_valid, op, a, b, shamt, mode, out_ready
//                       and observes in_ready, out_valid, result, flags.
//             slave  -> the ALU core side (directions reversed).
//  Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_core_if #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               mode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               flag_zero;
  logic               flag_sign;
  logic               flag_carry;

  modport master (
    output in_valid, op, a, b, shamt, mode, out_ready,
    input  in_ready, out_valid, result, flag_zero, flag_sign, flag_carry
  );

  modport slave (
    input  in_valid, op, a, b, shamt, mode, out_ready,
    output in_ready, out_valid, result, flag_zero, flag_sign, flag_carry
  );
endinterface
`default_nettype wire

// File: rtl/seq_alu_core.sv
`default_nettype none
// ============================================================================
//  Module   : seq_alu_core
//  Purpose  : Multi-cycle logic/shift/arithmetic/compare unit with a
//             registered Z/S/C status register. Shifts and rotates advance
//             one bit per cycle; all ops work in full-word or half-word mode.
//  Ports    : clk  - rising-edge clock
//             rst  - asynchronous active-high reset
//             bus  - seq_alu_core_if.slave (operation in, result/flags out)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_alu_core #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  seq_alu_core_if.slave   bus
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = SHAMT_W + 1;   // must hold WIDTH even when WIDTH == 2**SHAMT_W

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd8;
  localparam logic [3:0] OP_ADC = 4'd9;
  localparam logic [3:0] OP_SUB = 4'd10;
  localparam logic [3:0] OP_SBC = 4'd11;
  localparam logic [3:0] OP_INC = 4'd12;
  localparam logic [3:0] OP_DEC = 4'd13;
  localparam logic [3:0] OP_CMP = 4'd14;

  localparam logic [CNT_W-1:0] AW_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] AW_HALF = CNT_W'(HALF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         shop_q, shop_d;     // low op bits: 00 SHR, 01 SHL, 10 ROR, 11 ROL
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               sign_q, sign_d;
  logic               carry_q, carry_d;

  // Active-width helpers
  function automatic logic [WIDTH-1:0] aw_mask(input logic m);
    return m ? {WIDTH{1'b1}} : {{HALF{1'b0}}, {HALF{1'b1}}};
  endfunction

  function automatic logic aw_msb(input logic [WIDTH-1:0] v, input logic m);
    return m ? v[WIDTH-1] : v[HALF-1];
  endfunction

  function automatic logic aw_top_carry(input logic [WIDTH:0] v, input logic m);
    // Operands are masked to AW bits, so bit AW holds the carry/borrow.
    return m ? v[WIDTH] : v[HALF];
  endfunction

  function automatic logic [WIDTH-1:0] aw_top_bit(input logic m);
    return m ? {1'b1, {(WIDTH-1){1'b0}}} : {{HALF{1'b0}}, 1'b1, {(HALF-1){1'b0}}};
  endfunction

  // --------------------------------------------------------------------------
  // Single-cycle datapath, evaluated on the incoming operation
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_mask_in, w_am, w_bm;
  logic [WIDTH-1:0] w_add_rhs, w_sub_rhs;
  logic             w_add_cin, w_sub_bin;
  logic [WIDTH:0]   w_sum, w_diff;
  logic [WIDTH-1:0] w_alu_res, w_flag_src;
  logic             w_alu_c;
  logic             w_is_shift;
  logic [CNT_W-1:0] w_aw_in, w_shamt_ext, w_cnt_in;

  assign w_mask_in = aw_mask(bus.mode);
  assign w_am      = bus.a & w_mask_in;
  assign w_bm      = bus.b & w_mask_in;

  assign w_add_rhs = (bus.op == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_bm;
  assign w_sub_rhs = (bus.op == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_bm;
  assign w_add_cin = (bus.op == OP_ADC) & carry_q;
  assign w_sub_bin = (bus.op == OP_SBC) & carry_q;   // C as it stands at acceptance

  assign w_sum  = {1'b0, w_am} + {1'b0, w_add_rhs} + {{WIDTH{1'b0}}, w_add_cin};
  assign w_diff = {1'b0, w_am} - {1'b0, w_sub_rhs} - {{WIDTH{1'b0}}, w_sub_bin};

  always_comb begin
    w_alu_res = '0;
    w_alu_c   = carry_q;
    case (bus.op)
      OP_NOT:                 w_alu_res = ~w_am & w_mask_in;
      OP_AND:                 w_alu_res = w_am & w_bm;
      OP_OR:                  w_alu_res = w_am | w_bm;
      OP_XOR:                 w_alu_res = w_am ^ w_bm;
      OP_ADD, OP_ADC, OP_INC: begin
        w_alu_res = w_sum[WIDTH-1:0] & w_mask_in;
        w_alu_c   = aw_top_carry(w_sum, bus.mode);
      end
      OP_SUB, OP_SBC, OP_DEC: begin
        w_alu_res = w_diff[WIDTH-1:0] & w_mask_in;
        w_alu_c   = aw_top_carry(w_diff, bus.mode);
      end
      OP_CMP: begin
        w_alu_res = w_am;
        w_alu_c   = aw_top_carry(w_diff, bus.mode);
      end
      default:                w_alu_res = '0;   // NOP (shifts take their own path)
    endcase
  end

  // CMP reports flags of a-b while returning a unchanged.
  assign w_flag_src = (bus.op == OP_CMP) ? (w_diff[WIDTH-1:0] & w_mask_in) : w_alu_res;

  assign w_is_shift  = (bus.op[3:2] == 2'b01);
  assign w_aw_in     = bus.mode ? AW_FULL : AW_HALF;
  assign w_shamt_ext = {1'b0, bus.shamt};
  assign w_cnt_in    = (w_shamt_ext > w_aw_in) ? w_aw_in : w_shamt_ext;

  // --------------------------------------------------------------------------
  // One-bit shift/rotate step on the working register
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_shr, w_shl, w_step;
  logic             w_step_out;

  assign w_shr = work_q >> 1;
  assign w_shl = (work_q << 1) & aw_mask(mode_q);

  always_comb begin
    w_step     = w_shr;
    w_step_out = work_q[0];
    case (shop_q)
      2'b00: begin
        w_step     = w_shr;
        w_step_out = work_q[0];
      end
      2'b01: begin
        w_step     = w_shl;
        w_step_out = aw_msb(work_q, mode_q);
      end
      2'b10: begin
        w_step     = w_shr | (work_q[0] ? aw_top_bit(mode_q) : '0);
        w_step_out = work_q[0];
      end
      default: begin
        w_step     = w_shl | {{(WIDTH-1){1'b0}}, aw_msb(work_q, mode_q)};
        w_step_out = aw_msb(work_q, mode_q);
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    shop_d   = shop_q;
    mode_d   = mode_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    carry_d  = carry_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shop_d = bus.op[1:0];
          mode_d = bus.mode;
          if (w_is_shift) begin
            if (w_cnt_in == '0) begin
              // Zero-length shift: operand passes through, C untouched.
              state_d  = ST_DONE;
              result_d = w_am;
              zero_d   = (w_am == '0);
              sign_d   = aw_msb(w_am, bus.mode);
            end else begin
              state_d = ST_SHIFT;
              work_d  = w_am;
              cnt_d   = w_cnt_in;
            end
          end else begin
            state_d  = ST_DONE;
            result_d = w_alu_res;
            zero_d   = (w_flag_src == '0);
            sign_d   = aw_msb(w_flag_src, bus.mode);
            carry_d  = w_alu_c;
          end
        end
      end

      ST_SHIFT: begin
        work_d = w_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          result_d = w_step;
          zero_d   = (w_step == '0);
          sign_d   = aw_msb(w_step, mode_q);
          carry_d  = w_step_out;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shop_q   <= 2'b00;
      mode_q   <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shop_q   <= shop_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      carry_q  <= carry_d;
    end
  end

  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.out_valid  = (state_q == ST_DONE);
  assign bus.result     = result_q;
  assign bus.flag_zero  = zero_q;
  assign bus.flag_sign  = sign_q;
  assign bus.flag_carry = carry_q;

endmodule
`default_nettype wire
